// File: rtl/cbsc_mac_seq.sv
// Sequencer for the 4-lane CBSC MAC datapath: accepts an operand set, steps the
// datapath through clear/load/run, and returns the summed lane counts.
module cbsc_mac_seq #(
  parameter int N_BITS  = 7,
  parameter int N_LANES = 4,
  parameter int SUM_W   = N_BITS + $clog2(N_LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_LANES*N_BITS-1:0] in_x,
  input  logic [N_LANES*N_BITS-1:0] in_w,
  output logic [N_LANES*N_BITS-1:0] dp_x,
  output logic [N_LANES*N_BITS-1:0] dp_w,
  output logic                      dp_clr,
  output logic                      dp_load,
  output logic                      dp_en,
  input  logic [N_LANES-1:0]        lane_stop,
  input  logic [N_LANES*N_BITS-1:0] lane_cnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUM_W-1:0]          out_sum,
  output logic                      out_tmo,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, SUM, DONE} state_t;

  state_t            state, next_state;
  logic [N_BITS-1:0] cyc;
  logic [SUM_W-1:0]  lane_sum;
  logic              all_stop;
  logic              timeout;

  assign all_stop = &lane_stop;
  assign timeout  = (cyc == '1);

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < N_LANES; i++)
      lane_sum = lane_sum + SUM_W'(lane_cnt[i*N_BITS +: N_BITS]);
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    dp_clr     = 1'b0;
    dp_load    = 1'b0;
    dp_en      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = CLEAR;
      end
      CLEAR: begin
        dp_clr     = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        dp_load    = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        dp_en = 1'b1;
        if (all_stop || timeout) next_state = SUM;
      end
      SUM:  next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dp_x    <= '0;
      dp_w    <= '0;
      cyc     <= '0;
      out_sum <= '0;
      out_tmo <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && in_valid) begin
        dp_x <= in_x;
        dp_w <= in_w;
      end
      if (state == LOAD)
        cyc <= '0;
      else if (state == RUN)
        cyc <= cyc + N_BITS'(1);
      // all-stop takes priority over a coincident timeout
      if (state == RUN && (all_stop || timeout))
        out_tmo <= ~all_stop;
      if (state == SUM)
        out_sum <= lane_sum;
    end
  end

endmodule

// File: tb/tb_cbsc_mac_seq.sv
// Directed self-checking bench for cbsc_mac_seq; stimulus driven on the falling
// edge, outputs sampled on the falling edge.
module tb_cbsc_mac_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_x, in_w, dp_x, dp_w, lane_cnt;
  logic        dp_clr, dp_load, dp_en;
  logic [3:0]  lane_stop;
  logic        out_valid, out_ready, out_tmo, busy;
  logic [8:0]  out_sum;

  int checks = 0;
  int errors = 0;

  cbsc_mac_seq #(.N_BITS(7), .N_LANES(4), .SUM_W(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .dp_x(dp_x), .dp_w(dp_w), .dp_clr(dp_clr), .dp_load(dp_load), .dp_en(dp_en),
    .lane_stop(lane_stop), .lane_cnt(lane_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tmo(out_tmo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one operand set in IDLE and follows it cycle by cycle up to DONE.
  // Cycle n after the accepting edge: 0 CLEAR, 1 LOAD, 2..R+1 RUN, R+2 SUM, R+3 DONE.
  task automatic do_op(input logic [27:0] x, input logic [27:0] w, input logic [27:0] cnt,
                       input int stop_at, input logic [3:0] stuck, input int exp_r,
                       input logic [8:0] exp_sum, input logic exp_tmo);
    logic [5:0] expf;
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_x      = x;
    in_w      = w;
    lane_cnt  = cnt;
    lane_stop = '0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("dp_x_latched", 32'(dp_x), 32'(x));
    for (int n = 0; n <= exp_r + 3; n++) begin
      expf = {n == 0, n == 1, (n >= 2) && (n <= exp_r + 1), n == exp_r + 3, 1'b1, 1'b0};
      chk($sformatf("flags_c%0d", n),
          32'({dp_clr, dp_load, dp_en, out_valid, busy, in_ready}), 32'(expf));
      lane_stop = (n >= stop_at + 1) ? ~stuck : 4'b0000;
      if (n < exp_r + 3) @(negedge clk);
    end
    chk("out_sum", 32'(out_sum), 32'(exp_sum));
    chk("out_tmo", 32'(out_tmo), 32'(exp_tmo));
    chk("dp_w_held", 32'(dp_w), 32'(w));
    lane_stop = '0;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_valid", 32'(out_valid), 32'd0);
    chk("ret_ready", 32'(in_ready), 32'd1);
    chk("ret_busy", 32'(busy), 32'd0);
  endtask

  logic [27:0] exp_dpx;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    lane_cnt  = '0;
    lane_stop = '0;
    out_ready = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'({dp_clr, dp_load, dp_en, out_valid, busy, out_tmo}), 32'd0);
    chk("rst_dpx", 32'(dp_x), 32'd0);
    chk("rst_dpw", 32'(dp_w), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single op: w=5 each lane, all stop from RUN cycle 6, counts 3+4+5+6
    do_op({7'd5, 7'd5, 7'd5, 7'd5}, {7'd5, 7'd5, 7'd5, 7'd5},
          {7'd3, 7'd4, 7'd5, 7'd6}, 6, 4'b0000, 6, 9'd18, 1'b0);
    finish_op();

    // asynchronous reset in the middle of RUN
    in_x     = 28'h1234567;
    in_w     = 28'h0505050;
    lane_cnt = {7'd1, 7'd2, 7'd3, 7'd4};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_en", 32'(dp_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_flags", 32'({dp_en, out_valid, busy}), 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_dpx", 32'(dp_x), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_edge_ready", 32'(in_ready), 32'd1);
    chk("arst_edge_flags", 32'({dp_en, out_valid, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // stuck lane 2: run times out after 128 cycles
    do_op(28'h0a0b0c0, {4{7'd100}}, {7'd10, 7'd20, 7'd30, 7'd40},
          1, 4'b0100, 128, 9'd100, 1'b1);
    finish_op();

    // all-stop on the same edge as the timeout: all-stop wins
    do_op(28'h0000001, {4{7'd127}}, {7'd1, 7'd1, 7'd1, 7'd1},
          128, 4'b0000, 128, 9'd4, 1'b0);
    finish_op();

    // full-scale counts, no wrap
    do_op(28'hfffffff, 28'h0000000, {4{7'd127}}, 1, 4'b0000, 1, 9'd508, 1'b0);
    finish_op();

    // backpressure in DONE with a competing offer
    do_op(28'h5a5a5a5, {4{7'd2}}, {7'd9, 7'd8, 7'd7, 7'd6}, 2, 4'b0000, 2, 9'd30, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x = 28'h0f0f0f0 + 28'(i);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'd30);
      chk("bp_tmo", 32'(out_tmo), 32'd0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_dpx", 32'(dp_x), 32'h5a5a5a5);
    end
    in_valid = 1'b0;
    finish_op();

    // back-to-back with R=1: accept, CLEAR, LOAD, RUN, SUM, DONE, then IDLE again
    exp_dpx   = 28'h5a5a5a5;
    in_w      = '0;
    lane_stop = '1;
    lane_cnt  = {7'd1, 7'd2, 7'd3, 7'd4};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 24; j++) begin
      in_x = 28'h0100000 + 28'(j);
      chk($sformatf("b2b_ready_%0d", j), 32'(in_ready), 32'(j % 6 == 0));
      chk($sformatf("b2b_valid_%0d", j), 32'(out_valid), 32'(j % 6 == 5));
      if (j % 6 == 5) chk("b2b_sum", 32'(out_sum), 32'd10);
      if (j % 6 == 0) exp_dpx = in_x;
      @(negedge clk);
      chk($sformatf("b2b_dpx_%0d", j), 32'(dp_x), 32'(exp_dpx));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lane_stop = '0;
    @(negedge clk);
    chk("end_dpw", 32'(dp_w), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
